// File: rtl/line_arb_pkg.sv
// Shared definitions for the N-channel cacheline arbiter.
//   arb_state_e : top-level FSM encoding (IDLE -> BUSY -> DONE -> IDLE)
//   DEF_LINE_W  : default cacheline width in bits
//   DEF_ADDR_W  : default line address width in bits
//   ch_id_w()   : width of a channel id, never less than 1 bit
package line_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  localparam int DEF_LINE_W = 256;
  localparam int DEF_ADDR_W = 32;

  function automatic int ch_id_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/line_arbiter_n_picker.sv
// arb_picker: combinational grant selection for line_arbiter_n.
//   req   in  NUM_CH  per-channel request (read | write)
//   ptr   in  ID_W    rotating-priority start channel (ignored for fixed priority)
//   valid out 1       at least one request present
//   grant out ID_W    selected channel id
// Macro ARB_ROUND_ROBIN_EN: search starts at ptr and wraps; otherwise the
// lowest channel index wins.
module arb_picker
  import line_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ID_W   = ch_id_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   ptr,
  output logic              valid,
  output logic [ID_W-1:0]   grant
);

  assign valid = |req;

  generate
    if (NUM_CH == 1) begin : g_single
      logic unused_ptr;
      assign unused_ptr = ^ptr;
      assign grant      = '0;
    end else begin : g_multi
`ifdef ARB_ROUND_ROBIN_EN
      // Rotate so that bit 0 is channel ptr, pick the lowest set bit, then
      // add ptr back (mod NUM_CH) to recover the absolute channel id.
      logic [NUM_CH-1:0] rot;
      logic [ID_W-1:0]   off;
      logic [ID_W:0]     sum;
      always_comb begin
        rot = NUM_CH'({req, req} >> ptr);
        off = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (rot[i]) off = ID_W'(i);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (ID_W + 1)'(NUM_CH)) sum = sum - (ID_W + 1)'(NUM_CH);
        grant = sum[ID_W-1:0];
      end
`else
      logic unused_ptr;
      assign unused_ptr = ^ptr;
      always_comb begin
        grant = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (req[i]) grant = ID_W'(i);
        end
      end
`endif
    end
  endgenerate

endmodule

// File: rtl/line_arbiter_n.sv
// line_arbiter_n: multiplexes NUM_CH L1-side line requesters onto one
// downstream line port. One transaction in flight; request captured in IDLE,
// downstream op held in BUSY until pmem_resp, one-cycle ch_resp in DONE.
//   clk, rst                    clock, synchronous active-high reset
//   ch_read/ch_write[NUM_CH]    per-channel level requests (write wins if both)
//   ch_address/ch_wdata         per-channel packed address / write line
//   ch_resp[NUM_CH]             one-hot completion pulse
//   ch_rdata                    registered read line, valid with ch_resp
//   pmem_read/pmem_write        downstream op, level until pmem_resp
//   pmem_address/pmem_wdata     registered downstream address / write line
//   pmem_rdata/pmem_resp        downstream read line and completion
// Macro ARB_ROUND_ROBIN_EN selects rotating priority (default: fixed, ch0 first).
module line_arbiter_n
  import line_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int LINE_W = DEF_LINE_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_resp,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic                     pmem_read,
  output logic                     pmem_write,
  output logic [ADDR_W-1:0]        pmem_address,
  output logic [LINE_W-1:0]        pmem_wdata,
  input  logic [LINE_W-1:0]        pmem_rdata,
  input  logic                     pmem_resp
);

  localparam int ID_W = ch_id_w(NUM_CH);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]   ptr;

  logic [NUM_CH-1:0] req;
  logic              pick_vld;
  logic [ID_W-1:0]   pick_id;
  logic [ADDR_W-1:0] addr_arr  [NUM_CH];
  logic [LINE_W-1:0] wdata_arr [NUM_CH];

  assign req = ch_read | ch_write;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign addr_arr[i]  = ch_address[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = ch_wdata[i*LINE_W +: LINE_W];
    assign ch_resp[i]   = (state_q == DONE) && (gnt_q == ID_W'(i));
  end

  arb_picker #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_vld),
    .grant (pick_id)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Pointer advances past the winner only when a grant is actually taken.
  always_comb begin
    ptr_d = ptr_q;
    if (state_q == IDLE && pick_vld) begin
      ptr_d = (pick_id == ID_W'(NUM_CH - 1)) ? '0 : pick_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_id;
          wr_d    = ch_write[pick_id];  // write wins over a simultaneous read
          addr_d  = addr_arr[pick_id];
          wdata_d = wdata_arr[pick_id];
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;         // captured for writes too
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;          // no grant here: requester still dropping
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign pmem_read    = (state_q == BUSY) && !wr_q;
  assign pmem_write   = (state_q == BUSY) &&  wr_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign ch_rdata     = rdata_q;

endmodule

// File: tb/tb_line_arbiter_n.sv
// Self-checking bench for line_arbiter_n (4 channels, 64-bit lines).
// Grant order comes from a behavioural model of the arbitration rule
// (fixed or rotating, following ARB_ROUND_ROBIN_EN).
module tb_line_arbiter_n;
  localparam int N  = 4;
  localparam int LW = 64;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    ch_read, ch_write, ch_resp;
  logic [N*AW-1:0] ch_address;
  logic [N*LW-1:0] ch_wdata;
  logic [LW-1:0]   ch_rdata, pmem_wdata, pmem_rdata;
  logic            pmem_read, pmem_write, pmem_resp;
  logic [AW-1:0]   pmem_address;

  int checks = 0;
  int errors = 0;
  int ptr    = 0;   // model priority pointer

  always #5 clk = ~clk;

  line_arbiter_n #(.NUM_CH(N), .LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .ch_read(ch_read), .ch_write(ch_write),
    .ch_address(ch_address), .ch_wdata(ch_wdata),
    .ch_resp(ch_resp), .ch_rdata(ch_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: rotating search from ptr, or lowest index first.
  function automatic int pick(input logic [N-1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (req[(ptr + k) % N]) return (ptr + k) % N;
`else
    for (int c = 0; c < N; c++) if (req[c]) return c;
`endif
    return -1;
  endfunction

  task automatic set_req(input int c, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [LW-1:0] d);
    ch_read[c]             = rd;
    ch_write[c]            = wr;
    ch_address[c*AW +: AW] = a;
    ch_wdata[c*LW +: LW]   = d;
  endtask

  // Scribble over all data inputs; a BUSY transaction must not notice.
  task automatic scramble();
    for (int c = 0; c < N; c++) begin
      ch_address[c*AW +: AW] = $urandom;
      ch_wdata[c*LW +: LW]   = {$urandom, $urandom};
    end
  endtask

  // Called in an IDLE cycle with requests already applied. Runs one
  // transaction with `delay` BUSY cycles before pmem_resp.
  task automatic serve(input int delay, input logic [LW-1:0] rdat, input bit keep);
    logic [N-1:0]  req;
    int            g;
    bit            exp_wr;
    logic [AW-1:0] exp_a;
    logic [LW-1:0] exp_d;
    req = ch_read | ch_write;
    g   = pick(req);
    if (g < 0) begin
      chk("serve_no_request", LW'(req), LW'(1));
      return;
    end
    exp_wr = ch_write[g];
    exp_a  = ch_address[g*AW +: AW];
    exp_d  = ch_wdata[g*LW +: LW];
    ptr    = (g + 1) % N;
    tick();
    chk("busy_read",  LW'(pmem_read),  LW'(!exp_wr));
    chk("busy_write", LW'(pmem_write), LW'(exp_wr));
    chk("busy_addr",  LW'(pmem_address), LW'(exp_a));
    chk("busy_wdata", pmem_wdata, exp_d);
    chk("busy_noresp", LW'(ch_resp), '0);
    for (int k = 0; k < delay; k++) begin
      scramble();
      tick();
    end
    scramble();
    pmem_resp  = 1'b1;
    pmem_rdata = rdat;
    chk("hold_addr",  LW'(pmem_address), LW'(exp_a));
    chk("hold_wdata", pmem_wdata, exp_d);
    chk("hold_op",    LW'({pmem_read, pmem_write}), LW'({!exp_wr, exp_wr}));
    tick();
    pmem_resp  = 1'b0;
    pmem_rdata = {$urandom, $urandom};
    chk("done_resp",  LW'(ch_resp), LW'(1) << g);
    chk("done_rdata", ch_rdata, rdat);
    chk("done_pmem_idle", LW'({pmem_read, pmem_write}), '0);
    if (!keep) begin
      ch_read[g]  = 1'b0;
      ch_write[g] = 1'b0;
    end
    tick();
    chk("idle_noresp", LW'(ch_resp), '0);
  endtask

  initial begin
    rst        = 1'b1;
    ch_read    = '1;
    ch_write   = '0;
    ch_address = '0;
    ch_wdata   = '0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;

    // 1: reset with every channel requesting
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_pmem_op", LW'({pmem_read, pmem_write}), '0);
      chk("rst_resp",    LW'(ch_resp), '0);
      chk("rst_rdata",   ch_rdata, '0);
      chk("rst_addr",    LW'(pmem_address), '0);
      chk("rst_wdata",   pmem_wdata, '0);
    end
    rst     = 1'b0;
    ch_read = '0;
    tick();
    chk("post_rst_idle", LW'({pmem_read, pmem_write}), '0);

    // 2: single read on ch1
    set_req(1, 1'b1, 1'b0, 32'h0000_1040, '0);
    serve(4, {8{8'hA5}}, 1'b0);

    // 3: ch0 and ch1 keep re-requesting
    set_req(0, 1'b1, 1'b0, 32'h0000_2000, '0);
    set_req(1, 1'b1, 1'b0, 32'h0000_3000, '0);
    for (int k = 0; k < 4; k++) serve(k % 2, {$urandom, $urandom}, 1'b1);
    ch_read = '0;
    tick();

    // 4: push pointer to 3 via ch2, then requests 4'b1001
    set_req(2, 1'b1, 1'b0, 32'h0000_4400, '0);
    serve(1, {$urandom, $urandom}, 1'b0);
    set_req(0, 1'b1, 1'b0, 32'h0000_5000, '0);
    set_req(3, 1'b1, 1'b0, 32'h0000_6000, '0);
    serve(0, {$urandom, $urandom}, 1'b0);
    serve(2, {$urandom, $urandom}, 1'b0);

    // 5: write ch0 (data scrambled during BUSY), then read+write together
    set_req(0, 1'b0, 1'b1, 32'h0000_0080, 64'h0123_4567_89AB_CDEF);
    serve(3, {$urandom, $urandom}, 1'b0);
    set_req(0, 1'b1, 1'b1, 32'h0000_00C0, 64'hFEDC_BA98_7654_3210);
    serve(1, {$urandom, $urandom}, 1'b0);

    // 6: reset while BUSY abandons the op
    set_req(1, 1'b1, 1'b0, 32'h0000_7000, '0);
    tick();
    chk("rst_busy_pre", LW'(pmem_read), LW'(1));
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    ch_read = '0;
    ptr     = 0;
    chk("rst_busy_op",   LW'({pmem_read, pmem_write}), '0);
    chk("rst_busy_resp", LW'(ch_resp), '0);
    pmem_resp = 1'b1;
    tick();
    pmem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy_quiet", LW'({ch_resp, pmem_read, pmem_write}), '0);
      tick();
    end

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < N; c++) begin
        if (!(ch_read[c] | ch_write[c]) && $urandom_range(1, 0) == 1) begin
          if ($urandom_range(1, 0) == 1) set_req(c, 1'b0, 1'b1, $urandom, {$urandom, $urandom});
          else                           set_req(c, 1'b1, 1'b0, $urandom, {$urandom, $urandom});
        end
      end
      if ((ch_read | ch_write) == '0) set_req($urandom_range(N - 1, 0), 1'b1, 1'b0, $urandom, '0);
      serve($urandom_range(3, 0), {$urandom, $urandom}, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
